// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - single-request memory cycle sequencer (IDLE/SETUP/ACCESS/HOLD)
// Every output is a flop; strobes, status and memory-side fields change only on CLK or RESET.
module mem_access_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        WR,
  input  logic        BYTE,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  input  logic [15:0] MEM_DIN,
  input  logic        MEM_RDY,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_DOUT,
  output logic [1:0]  MEM_BE,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic        wr_q;
  logic        byte_q;
  logic        lane_hi;
  logic        misaligned;
  logic [15:0] read_value;

  assign misaligned = !BYTE && ADDR[0];
  // Byte reads return the addressed lane zero-extended into the low byte.
  assign read_value = !byte_q ? MEM_DIN
                    : (lane_hi ? {8'h00, MEM_DIN[15:8]} : {8'h00, MEM_DIN[7:0]});

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      lane_hi  <= 1'b0;
      MEM_ADDR <= 16'h0000;
      MEM_DOUT <= 16'h0000;
      MEM_BE   <= 2'b00;
      MEM_RD   <= 1'b0;
      MEM_WR   <= 1'b0;
      RDATA    <= 16'h0000;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            if (misaligned) begin
              DONE <= 1'b1;
              ERR  <= 1'b1;
            end else begin
              state    <= ST_SETUP;
              BUSY     <= 1'b1;
              wait_cnt <= 8'd0;
              wr_q     <= WR;
              byte_q   <= BYTE;
              lane_hi  <= ADDR[0];
              MEM_ADDR <= {ADDR[15:1], 1'b0};
              MEM_DOUT <= BYTE ? {WDATA[7:0], WDATA[7:0]} : WDATA;
              MEM_BE   <= BYTE ? (ADDR[0] ? 2'b10 : 2'b01) : 2'b11;
            end
          end
        end
        ST_SETUP: begin
          state  <= ST_ACCESS;
          MEM_RD <= !wr_q;
          MEM_WR <= wr_q;
        end
        ST_ACCESS: begin
          // A ready in the timeout cycle still counts as success.
          if (MEM_RDY) begin
            state  <= ST_HOLD;
            MEM_RD <= 1'b0;
            MEM_WR <= 1'b0;
            DONE   <= 1'b1;
            if (!wr_q) begin
              RDATA <= read_value;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            state  <= ST_HOLD;
            MEM_RD <= 1'b0;
            MEM_WR <= 1'b0;
            DONE   <= 1'b1;
            ERR    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed table plus randomized transactions against a transaction-level model
module tb_mem_access_sequencer;
  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        RESET, START, WR, BYTE, MEM_RDY;
  logic [15:0] ADDR, WDATA, MEM_DIN;
  logic [15:0] MEM_ADDR, MEM_DOUT, RDATA;
  logic [1:0]  MEM_BE;
  logic        MEM_RD, MEM_WR, BUSY, DONE, ERR;

  mem_access_sequencer #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .WR(WR), .BYTE(BYTE),
    .ADDR(ADDR), .WDATA(WDATA), .MEM_DIN(MEM_DIN), .MEM_RDY(MEM_RDY),
    .MEM_ADDR(MEM_ADDR), .MEM_DOUT(MEM_DOUT), .MEM_BE(MEM_BE),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .RDATA(RDATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic        byt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    int          delay;
    logic [15:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_dout;
    logic [15:0] e_rdata;
    logic        e_err;
    int          e_done;
    int          e_strobes;
  } vec_t;

  typedef struct {
    int          done_cyc;
    logic        err;
    int          strobes;
    int          first_strobe;
    logic        kind_ok;
    logic        stable_ok;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] dout;
    int          busy_cnt;
    logic [15:0] rdata;
    logic        done_after;
    logic        busy_after;
  } obs_t;

  vec_t        tbl [8];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: strobe length, latency, status and read result from the rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit   ok;
    r.e_addr = v.addr & 16'hFFFE;
    r.e_be   = !v.byt ? 2'b11 : (v.addr[0] ? 2'b10 : 2'b01);
    r.e_dout = v.byt ? {v.wdata[7:0], v.wdata[7:0]} : v.wdata;
    if (!v.byt && v.addr[0]) begin
      r.e_done = 1; r.e_err = 1'b1; r.e_strobes = 0;
    end else begin
      ok          = v.delay < TO;
      r.e_strobes = ok ? v.delay + 1 : TO;
      r.e_done    = 2 + r.e_strobes;
      r.e_err     = !ok;
      if (ok && !v.wr)
        model_rdata = !v.byt ? v.din : (v.addr[0] ? (v.din >> 8) : (v.din & 16'h00FF));
    end
    r.e_rdata = model_rdata;
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input bit hold, output obs_t o);
    o = '{done_cyc: -1, err: 1'b0, strobes: 0, first_strobe: -1, kind_ok: 1'b1, stable_ok: 1'b1,
          addr: 16'h0, be: 2'b0, dout: 16'h0, busy_cnt: 0, rdata: 16'h0, done_after: 1'b0, busy_after: 1'b0};
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (c > 0) begin
        if (MEM_RD || MEM_WR) begin
          o.strobes++;
          if (o.first_strobe < 0) begin
            o.first_strobe = c; o.addr = MEM_ADDR; o.be = MEM_BE; o.dout = MEM_DOUT;
          end else if (MEM_ADDR !== o.addr || MEM_BE !== o.be || MEM_DOUT !== o.dout) begin
            o.stable_ok = 1'b0;
          end
          if ((MEM_RD && MEM_WR) || (MEM_WR != v.wr)) o.kind_ok = 1'b0;
        end
        if (o.done_cyc >= 0 && c == o.done_cyc + 1) begin
          o.done_after = DONE; o.busy_after = BUSY;
          START = 1'b0; MEM_RDY = 1'b0;
          return;
        end
        if (BUSY) o.busy_cnt++;
        if (DONE && o.done_cyc < 0) begin
          o.done_cyc = c; o.err = ERR; o.rdata = RDATA;
        end
      end
      START = (c == 0) || (hold && (o.done_cyc < 0 || c == o.done_cyc));
      if (c == 0) begin
        WR = v.wr; BYTE = v.byt; ADDR = v.addr; WDATA = v.wdata;
      end else begin
        WR = 1'($urandom); BYTE = 1'($urandom); ADDR = 16'($urandom); WDATA = 16'($urandom);
      end
      MEM_DIN = v.din;
      MEM_RDY = (MEM_RD || MEM_WR) && (o.strobes - 1 == v.delay);
    end
    START = 1'b0; MEM_RDY = 1'b0;
  endtask

  task automatic run_and_check(input vec_t v, input bit hold, input string tag);
    obs_t o;
    run_txn(v, hold, o);
    check({tag, " done_cycle"}, o.done_cyc, v.e_done);
    check({tag, " err"}, o.err, v.e_err);
    check({tag, " strobe_cycles"}, o.strobes, v.e_strobes);
    check({tag, " busy_cycles"}, o.busy_cnt, (v.e_strobes == 0) ? 0 : v.e_done);
    check({tag, " rdata"}, o.rdata, v.e_rdata);
    check({tag, " done_pulse_end"}, o.done_after, 1'b0);
    check({tag, " busy_after"}, o.busy_after, 1'b0);
    if (v.e_strobes > 0) begin
      check({tag, " first_strobe"}, o.first_strobe, 2);
      check({tag, " strobe_kind"}, o.kind_ok, 1'b1);
      check({tag, " stable"}, o.stable_ok, 1'b1);
      check({tag, " mem_addr"}, o.addr, v.e_addr);
      check({tag, " mem_be"}, o.be, v.e_be);
      check({tag, " mem_dout"}, o.dout, v.e_dout);
    end
  endtask

  initial begin
    vec_t v;
    bit   hold;
    int   dsel;
    int   seen;

    tbl[0] = '{1'b0, 1'b0, 16'h1234, 16'h1111, 16'hBEEF, 0,  16'h1234, 2'b11, 16'h1111, 16'hBEEF, 1'b0, 3,  1};
    tbl[1] = '{1'b1, 1'b1, 16'h0101, 16'h00A5, 16'h0000, 2,  16'h0100, 2'b10, 16'hA5A5, 16'hBEEF, 1'b0, 5,  3};
    tbl[2] = '{1'b0, 1'b1, 16'h0007, 16'h0000, 16'h3C5A, 3,  16'h0006, 2'b10, 16'h0000, 16'h003C, 1'b0, 6,  4};
    tbl[3] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h7777, 0,  16'h0000, 2'b00, 16'h0000, 16'h003C, 1'b1, 1,  0};
    tbl[4] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1357, 99, 16'h0040, 2'b11, 16'h0000, 16'h003C, 1'b1, 17, 15};
    tbl[5] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h2468, 14, 16'h0040, 2'b11, 16'h0000, 16'h2468, 1'b0, 17, 15};
    tbl[6] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hABCD, 0,  16'h0010, 2'b01, 16'h0000, 16'h00CD, 1'b0, 3,  1};
    tbl[7] = '{1'b1, 1'b0, 16'h0022, 16'hCAFE, 16'h0000, 1,  16'h0022, 2'b11, 16'hCAFE, 16'h00CD, 1'b0, 4,  2};

    RESET = 1'b1; START = 1'b0; WR = 1'b0; BYTE = 1'b0;
    ADDR = 16'h0; WDATA = 16'h0; MEM_DIN = 16'h0; MEM_RDY = 1'b0;
    #3;
    check("reset outputs", {MEM_ADDR, MEM_DOUT}, 32'h0);
    check("reset strobes_be", {MEM_RD, MEM_WR, MEM_BE}, 4'b0);
    check("reset status", {RDATA, BUSY, DONE, ERR}, 19'h0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    foreach (tbl[i]) run_and_check(tbl[i], 1'b0, $sformatf("table%0d", i));
    model_rdata = 16'h00CD;

    // START held through the whole cycle, including HOLD, must not queue a second access.
    v = '{1'b0, 1'b0, 16'h0A0A, 16'h0000, 16'h5A5A, 1, 16'h0, 2'b0, 16'h0, 16'h0, 1'b0, 0, 0};
    run_and_check(model(v), 1'b1, "start_held");

    for (int k = 0; k < 30; k++) begin
      v.wr = 1'($urandom); v.byt = 1'($urandom);
      v.addr = 16'($urandom); v.wdata = 16'($urandom); v.din = 16'($urandom);
      dsel = $urandom_range(0, 7);
      v.delay = (dsel < 4) ? dsel : (dsel == 4) ? 13 : (dsel == 5) ? 14 : (dsel == 6) ? 15 : 20;
      v = model(v);
      hold = (v.e_strobes > 0) && 1'($urandom);
      run_and_check(v, hold, $sformatf("rand%0d", k));
    end

    // Reset in the middle of ACCESS: strobes and BUSY drop without a clock, no DONE follows.
    @(negedge CLK);
    START = 1'b1; WR = 1'b0; BYTE = 1'b0; ADDR = 16'h0200; MEM_RDY = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    seen = 0;
    for (int c = 0; c < 5 && seen == 0; c++) begin
      @(negedge CLK);
      if (MEM_RD) seen = 1;
    end
    check("midreset strobe_seen", seen, 1);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("midreset strobes", {MEM_RD, MEM_WR}, 2'b00);
    check("midreset busy_done", {BUSY, DONE, ERR}, 3'b000);
    check("midreset be_rdata", {MEM_BE, RDATA}, 18'h0);
    @(negedge CLK);
    RESET = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      if (DONE || BUSY) seen = 1;
    end
    check("midreset no_done", seen, 0);
    model_rdata = 16'h0000;
    v = '{1'b0, 1'b1, 16'h0301, 16'h0000, 16'h9ABC, 2, 16'h0, 2'b0, 16'h0, 16'h0, 1'b0, 0, 0};
    run_and_check(model(v), 1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
